rf_writeback_arbiter: RTL and testbench
=======================================

// Module: rf_writeback_arbiter
// PURPOSE
//  Writer side of the 64-bit, 32-entry CPU register file. Merges execute-stage results and
//  out-of-order load returns (data memory / NIC) into the single RF write port
//  (write_enb/di/sel/addr_wr), buffering loads on collision. Keeps a load-pending scoreboard
//  that drives read-operand hazard flags back to decode.
// PARAMETERS
//  LQ_DEPTH  2   load-return queue entries (power of 2, >=2)
//  DW        64  data width, big-endian [0:DW-1]
//  AW        5   register address width
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   asynchronous, active-high; clears all state
//  ex_valid      in   1   execute result valid this cycle (no backpressure)
//  ex_addr       in   AW  execute destination register
//  ex_data       in   DW  execute result
//  ex_sel        in   3   partial-write mode for execute result
//  ld_issue      in   1   load issued this cycle; marks ld_issue_addr pending
//  ld_issue_addr in   AW  destination of issued load
//  ld_rsp_valid  in   1   load return valid
//  ld_rsp_ready  out  1   queue can accept (= queue not full)
//  ld_rsp_addr   in   AW  load return destination
//  ld_rsp_data   in   DW  load return data
//  ld_rsp_sel    in   3   partial-write mode for load return
//  rd_addr_0/1   in   AW  decode source operand addresses
//  hazard_0/1    out  1   source operand has a load pending
//  wr_enb        out  1   to RF write_enb
//  wr_addr       out  AW  to RF addr_wr
//  wr_data       out  DW  to RF di
//  wr_sel        out  3   to RF sel
// BEHAVIOUR
//  - Sel codes: 000 ALL, 001 UPP [0:31], 010 LOW [32:63], 011 EVEN bytes, 100 ODD bytes;
//    101-111 passed through unchanged (RF ignores them).
//  - Write outputs are registered. Reset: wr_enb=0, wr_addr=0, wr_data=0, wr_sel=000,
//    queue empty, ld_rsp_ready=1, scoreboard all clear, hazard_0/1=0.
//  - Per cycle, source for the next output register load, in priority order:
//    1) ex_valid=1 -> execute result (latency 1 cycle).
//    2) queue non-empty -> pop head.
//    3) queue empty and load return accepted this cycle -> bypass directly (latency 1), no enqueue.
//    4) none -> wr_enb=0; wr_addr/data/sel hold their last values.
//  - Accept when ld_rsp_valid && ld_rsp_ready. Accepted and not bypassed -> enqueue at tail.
//    Simultaneous push and pop is legal whenever count>0.
//  - ld_rsp_ready = (count != LQ_DEPTH). Registered-count-only; no combinational path from
//    ex_valid or ld_rsp_valid.
//  - Pointer wrap modulo LQ_DEPTH. Count width is clog2(LQ_DEPTH)+1.
//  - Address 0 passes through to the RF (RF discards it).
//  - Scoreboard busy[1:31]:
//    - Set on ld_issue (addr 0 ignored).
//    - Cleared at the edge that loads a load-sourced write into the output register. The
//      RF forwards that write the same cycle, so the hazard drops exactly when the data is
//      readable.
//    - Set and clear of the same address in the same cycle: set wins.
//  - hazard_n = busy[rd_addr_n] && rd_addr_n!=0. Combinational from registered busy.
//  - Upstream guarantees (checked by assertions, not handled):
//    - No ld_issue to a busy register.
//    - No ex_valid to a busy register.
//    - Every load return matches a pending busy bit.
//  - Reset asserted mid-operation: queued returns are dropped and the scoreboard clears;
//    the pipeline flushes concurrently.
// STRUCTURE
//  - Shared include rf_defs.vh:
//    - REGFILE_WIDTH / REGFILE_DEPTH / REGFILE_AWIDTH.
//    - Sel mode constants ALL/UPP/LOW/EVEN/ODD.
//    - Write-port bundle field widths.
//    Used by the register file and this block alike.
//  - Sub-module rf_wb_load_fifo: parameterised synchronous FIFO storing {addr,sel,data},
//    with push/pop/full/empty/count. Arbitration, bypass and scoreboard stay in the top.
// TESTING
//  1. Reset then idle: wr_enb=0, ld_rsp_ready=1, hazards 0.
//     ex_valid addr=5 data=0x0123456789ABCDEF sel=000 -> next cycle wr_enb=1, addr=5,
//     same data, sel=000.
//  2. ld_issue addr=7; rd_addr_0=7 -> hazard_0=1. Return addr=7 sel=010 alone, queue empty
//     -> bypass, wr_enb next cycle; hazard_0 falls at that same edge.
//  3. ex_valid and ld_rsp_valid every cycle for 3 cycles:
//     - ex writes each cycle.
//     - Queue fills to 2, ld_rsp_ready=0 at cycle 3.
//     - After ex stops, loads drain in FIFO order on consecutive cycles.
//  4. Queue full with pop and valid return in the same cycle: ready stays 0 that cycle and
//     nothing is accepted. Next cycle ready=1 and the return is accepted; no entry lost or
//     duplicated.
//  5. ld_issue addr=9 and a load-sourced write to addr=9 in the same cycle -> busy[9] stays 1.
//     ld_issue addr=0 -> no hazard.
//  6. Assert reset with 2 entries queued and 3 busy bits:
//     - Outputs clear immediately (async).
//     - After release: ready=1, no stale writes, hazards 0.

Source files
------------

// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared register-file definitions: geometry, sel write modes and write-port field widths.
// Used by the register file and by its writeback arbiter.
package rf_writeback_arbiter_pkg;

  localparam int unsigned REGFILE_WIDTH  = 64;
  localparam int unsigned REGFILE_DEPTH  = 32;
  localparam int unsigned REGFILE_AWIDTH = 5;
  localparam int unsigned SEL_W          = 3;
  localparam int unsigned LQ_DEPTH_DEF   = 2;

  // Partial-write modes understood by the RF; codes 101-111 are ignored by it.
  typedef enum logic [SEL_W-1:0] {
    SEL_ALL  = 3'b000,
    SEL_UPP  = 3'b001,
    SEL_LOW  = 3'b010,
    SEL_EVEN = 3'b011,
    SEL_ODD  = 3'b100
  } sel_e;

  // Width of one write-port bundle {addr, sel, data}.
  function automatic int unsigned wb_entry_width(int unsigned aw, int unsigned dw);
    return aw + SEL_W + dw;
  endfunction

endpackage

// File: rtl/rf_wb_load_fifo.sv
// Small synchronous FIFO holding load returns {addr, sel, data} that lost arbitration
// for the RF write port. Caller never pushes when full or pops when empty.
module rf_wb_load_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned W     = 72,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges execute results and out-of-order load returns onto the single RF write port,
// and tracks pending loads to flag read-operand hazards back to decode.
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = LQ_DEPTH_DEF,
  parameter int unsigned DW       = REGFILE_WIDTH,
  parameter int unsigned AW       = REGFILE_AWIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [AW-1:0]    ex_addr,
  input  logic [0:DW-1]    ex_data,
  input  logic [SEL_W-1:0] ex_sel,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_issue_addr,
  input  logic             ld_rsp_valid,
  output logic             ld_rsp_ready,
  input  logic [AW-1:0]    ld_rsp_addr,
  input  logic [0:DW-1]    ld_rsp_data,
  input  logic [SEL_W-1:0] ld_rsp_sel,
  input  logic [AW-1:0]    rd_addr_0,
  input  logic [AW-1:0]    rd_addr_1,
  output logic             hazard_0,
  output logic             hazard_1,
  output logic             wr_enb,
  output logic [AW-1:0]    wr_addr,
  output logic [0:DW-1]    wr_data,
  output logic [SEL_W-1:0] wr_sel
);

  localparam int unsigned EW   = wb_entry_width(AW, DW);
  localparam int unsigned CW   = $clog2(LQ_DEPTH) + 1;
  localparam int unsigned NREG = 1 << AW;

  logic [EW-1:0]    q_head, rsp_entry;
  logic             q_full, q_empty, q_push, q_pop;
  logic [CW-1:0]    q_count;
  logic [AW-1:0]    h_addr;
  logic [SEL_W-1:0] h_sel;
  logic [0:DW-1]    h_data;
  logic             accept, bypass, clr_en;
  logic [AW-1:0]    clr_addr;

  logic             wr_enb_q, wr_enb_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [0:DW-1]    wr_data_q, wr_data_d;
  logic [SEL_W-1:0] wr_sel_q, wr_sel_d;
  logic [NREG-1:0]  busy_q, busy_d;

  rf_wb_load_fifo #(
    .DEPTH (LQ_DEPTH),
    .W     (EW)
  ) u_load_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .din   (rsp_entry),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Ready depends only on the registered occupancy.
  assign ld_rsp_ready = (q_count != CW'(LQ_DEPTH));
  assign accept       = ld_rsp_valid && ld_rsp_ready;
  assign rsp_entry    = {ld_rsp_addr, ld_rsp_sel, ld_rsp_data};
  assign {h_addr, h_sel, h_data} = q_head;

  // Write-port source priority: execute, queued load, bypassed fresh load, else idle.
  always_comb begin
    wr_enb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_sel_d  = wr_sel_q;
    q_pop     = 1'b0;
    bypass    = 1'b0;
    clr_en    = 1'b0;
    clr_addr  = '0;
    if (ex_valid) begin
      wr_enb_d  = 1'b1;
      wr_addr_d = ex_addr;
      wr_data_d = ex_data;
      wr_sel_d  = ex_sel;
    end else if (!q_empty) begin
      wr_enb_d  = 1'b1;
      wr_addr_d = h_addr;
      wr_data_d = h_data;
      wr_sel_d  = h_sel;
      q_pop     = 1'b1;
      clr_en    = 1'b1;
      clr_addr  = h_addr;
    end else if (accept) begin
      wr_enb_d  = 1'b1;
      wr_addr_d = ld_rsp_addr;
      wr_data_d = ld_rsp_data;
      wr_sel_d  = ld_rsp_sel;
      bypass    = 1'b1;
      clr_en    = 1'b1;
      clr_addr  = ld_rsp_addr;
    end
    q_push = accept && !bypass;

    // A new issue to a register whose load is retiring this cycle keeps it busy.
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (ld_issue) begin
      busy_d[ld_issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_enb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_sel_q  <= '0;
      busy_q    <= '0;
    end else begin
      wr_enb_q  <= wr_enb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_sel_q  <= wr_sel_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_enb   = wr_enb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_sel   = wr_sel_q;
  assign hazard_0 = busy_q[rd_addr_0] && (rd_addr_0 != '0);
  assign hazard_1 = busy_q[rd_addr_1] && (rd_addr_1 != '0);

  // Upstream contract: these are caller bugs, not conditions the block recovers from.
  a_issue_not_busy: assert property (@(posedge clk) disable iff (reset)
    (ld_issue && ld_issue_addr != '0) |->
      (!busy_q[ld_issue_addr] || (clr_en && clr_addr == ld_issue_addr)));
  a_ex_not_busy: assert property (@(posedge clk) disable iff (reset)
    (ex_valid && ex_addr != '0) |-> !busy_q[ex_addr]);
  a_rsp_pending: assert property (@(posedge clk) disable iff (reset)
    (accept && ld_rsp_addr != '0) |-> busy_q[ld_rsp_addr]);
  a_full_ready: assert property (@(posedge clk) disable iff (reset)
    q_full == !ld_rsp_ready);

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed scenarios followed by constrained-random traffic, compared each cycle
// against a queue-based reference model of the writeback port and load scoreboard.
module tb_rf_writeback_arbiter;

  localparam int LQ = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [4:0]  ex_addr;
  logic [0:63] ex_data;
  logic [2:0]  ex_sel;
  logic        ld_issue;
  logic [4:0]  ld_issue_addr;
  logic        ld_rsp_valid;
  logic        ld_rsp_ready;
  logic [4:0]  ld_rsp_addr;
  logic [0:63] ld_rsp_data;
  logic [2:0]  ld_rsp_sel;
  logic [4:0]  rd_addr_0, rd_addr_1;
  logic        hazard_0, hazard_1;
  logic        wr_enb;
  logic [4:0]  wr_addr;
  logic [0:63] wr_data;
  logic [2:0]  wr_sel;

  rf_writeback_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_addr       (ex_addr),
    .ex_data       (ex_data),
    .ex_sel        (ex_sel),
    .ld_issue      (ld_issue),
    .ld_issue_addr (ld_issue_addr),
    .ld_rsp_valid  (ld_rsp_valid),
    .ld_rsp_ready  (ld_rsp_ready),
    .ld_rsp_addr   (ld_rsp_addr),
    .ld_rsp_data   (ld_rsp_data),
    .ld_rsp_sel    (ld_rsp_sel),
    .rd_addr_0     (rd_addr_0),
    .rd_addr_1     (rd_addr_1),
    .hazard_0      (hazard_0),
    .hazard_1      (hazard_1),
    .wr_enb        (wr_enb),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_sel        (wr_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [2:0]  sel;
    logic [63:0] data;
  } ld_t;

  // Reference model state
  ld_t         mq[$];
  logic [4:0]  pend[$];
  logic [31:0] mbusy;
  logic        exp_enb;
  logic [4:0]  exp_addr;
  logic [63:0] exp_data;
  logic [2:0]  exp_sel;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    pend.delete();
    mbusy    = '0;
    exp_enb  = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_sel  = '0;
  endtask

  task automatic model_step();
    logic        acc;
    logic        byp;
    ld_t         r, h;
    logic [31:0] nb;
    acc    = ld_rsp_valid && (mq.size() != LQ);
    byp    = 1'b0;
    r.addr = ld_rsp_addr;
    r.sel  = ld_rsp_sel;
    r.data = ld_rsp_data;
    nb     = mbusy;
    if (acc) begin
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i] == r.addr) begin
          pend.delete(i);
          break;
        end
      end
    end
    if (ex_valid) begin
      exp_enb = 1'b1; exp_addr = ex_addr; exp_data = ex_data; exp_sel = ex_sel;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      exp_enb = 1'b1; exp_addr = h.addr; exp_data = h.data; exp_sel = h.sel;
      nb[h.addr] = 1'b0;
    end else if (acc) begin
      exp_enb = 1'b1; exp_addr = r.addr; exp_data = r.data; exp_sel = r.sel;
      nb[r.addr] = 1'b0;
      byp = 1'b1;
    end else begin
      exp_enb = 1'b0;
    end
    if (acc && !byp) mq.push_back(r);
    if (ld_issue && ld_issue_addr != 0) begin
      nb[ld_issue_addr] = 1'b1;
      pend.push_back(ld_issue_addr);
    end
    mbusy = nb;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    check("wr_enb",       wr_enb,       exp_enb);
    check("wr_addr",      wr_addr,      exp_addr);
    check("wr_data",      wr_data,      exp_data);
    check("wr_sel",       wr_sel,       exp_sel);
    check("ld_rsp_ready", ld_rsp_ready, mq.size() != LQ);
    check("hazard_0",     hazard_0,     mbusy[rd_addr_0] && rd_addr_0 != 0);
    check("hazard_1",     hazard_1,     mbusy[rd_addr_1] && rd_addr_1 != 0);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    ex_valid     = 1'b0;
    ld_issue     = 1'b0;
    ld_rsp_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a);
    idle();
    ld_issue      = 1'b1;
    ld_issue_addr = a;
    cycle();
    idle();
  endtask

  function automatic logic [4:0] pick_free();
    logic [4:0] a;
    for (int t = 0; t < 64; t++) begin
      a = 5'($urandom_range(31));
      if (a != 0 && !mbusy[a]) return a;
    end
    return 5'd0;
  endfunction

  initial begin
    logic [63:0] t1_data;
    int          idx;
    t1_data = 64'h0123456789ABCDEF;
    reset = 1'b1;
    idle();
    ex_addr = '0; ex_data = '0; ex_sel = '0; ld_issue_addr = '0;
    ld_rsp_addr = '0; ld_rsp_data = '0; ld_rsp_sel = '0;
    rd_addr_0 = '0; rd_addr_1 = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: idle after reset, then a plain execute write
    cycle();
    ex_valid = 1'b1; ex_addr = 5'd5; ex_data = t1_data; ex_sel = 3'b000;
    cycle();
    idle();
    #1 check("t1_ex_data", wr_data, t1_data);
    cycle();

    // 2: load hazard, bypassed return, hazard drops with the write
    issue(5'd7);
    rd_addr_0 = 5'd7;
    #1 check("t2_haz_set", hazard_0, 1'b1);
    ld_rsp_valid = 1'b1; ld_rsp_addr = 5'd7; ld_rsp_sel = 3'b010;
    ld_rsp_data = 64'hDEADBEEF_CAFEF00D;
    cycle();
    idle();
    #1 check("t2_bypass_enb", wr_enb, 1'b1);
    check("t2_haz_clr", hazard_0, 1'b0);
    cycle();

    // 3/4: collisions fill the queue, full+pop rejects, then drain in order
    issue(5'd10); issue(5'd11); issue(5'd12);
    for (int i = 0; i < 5; i++) begin
      ex_valid     = (i < 3);
      ex_addr      = 5'(1 + i);
      ex_data      = {$urandom, $urandom};
      ex_sel       = 3'(i);
      ld_rsp_valid = 1'b1;
      ld_rsp_addr  = (i < 2) ? 5'(10 + i) : 5'd12;
      ld_rsp_data  = {$urandom, $urandom};
      ld_rsp_sel   = 3'(i + 1);
      if (i == 2 || i == 3) #1 check("t3_ready_low", ld_rsp_ready, 1'b0);
      cycle();
    end
    idle();
    repeat (4) cycle();

    // 5: issue and retire of the same register in one cycle; issue to r0
    issue(5'd9);
    rd_addr_0 = 5'd9;
    ld_rsp_valid = 1'b1; ld_rsp_addr = 5'd9; ld_rsp_sel = 3'b011; ld_rsp_data = {$urandom, $urandom};
    ld_issue = 1'b1; ld_issue_addr = 5'd9;
    cycle();
    idle();
    #1 check("t5_busy_kept", hazard_0, 1'b1);
    rd_addr_1 = 5'd0;
    ld_issue = 1'b1; ld_issue_addr = 5'd0;
    cycle();
    idle();
    #1 check("t5_r0_no_haz", hazard_1, 1'b0);
    ld_rsp_valid = 1'b1; ld_rsp_addr = 5'd9; ld_rsp_sel = 3'b100; ld_rsp_data = {$urandom, $urandom};
    cycle();
    idle();
    repeat (2) cycle();

    // 6: reset with two queued returns and three busy registers
    issue(5'd20); issue(5'd21); issue(5'd22);
    for (int i = 0; i < 2; i++) begin
      ex_valid = 1'b1; ex_addr = 5'(2 + i); ex_data = {$urandom, $urandom}; ex_sel = 3'b000;
      ld_rsp_valid = 1'b1; ld_rsp_addr = 5'(20 + i); ld_rsp_data = {$urandom, $urandom}; ld_rsp_sel = 3'b001;
      cycle();
    end
    idle();
    rd_addr_0 = 5'd20; rd_addr_1 = 5'd22;
    #1 check("t6_haz_pre", hazard_0, 1'b1);
    check("t6_ready_pre", ld_rsp_ready, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_enb",   wr_enb,       1'b0);
    check("t6_rst_addr",  wr_addr,      5'd0);
    check("t6_rst_data",  wr_data,      64'd0);
    check("t6_rst_sel",   wr_sel,       3'd0);
    check("t6_rst_ready", ld_rsp_ready, 1'b1);
    check("t6_rst_haz0",  hazard_0,     1'b0);
    check("t6_rst_haz1",  hazard_1,     1'b0);
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) cycle();

    // Random traffic honouring the upstream contract
    for (int n = 0; n < 3000; n++) begin
      ex_valid = 1'($urandom_range(1));
      ex_addr  = ($urandom_range(7) == 0) ? 5'd0 : pick_free();
      ex_data  = {$urandom, $urandom};
      ex_sel   = 3'($urandom_range(7));
      ld_issue = (pend.size() < 6) && ($urandom_range(2) == 0);
      ld_issue_addr = ($urandom_range(7) == 0) ? 5'd0 : pick_free();
      ld_rsp_valid = (pend.size() > 0) && ($urandom_range(1) == 1);
      if (pend.size() > 0) begin
        idx = int'($urandom_range(pend.size() - 1));
        ld_rsp_addr = pend[idx];
      end
      ld_rsp_data = {$urandom, $urandom};
      ld_rsp_sel  = 3'($urandom_range(7));
      rd_addr_0   = 5'($urandom_range(31));
      rd_addr_1   = 5'($urandom_range(31));
      cycle();
    end
    idle();
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
